// File: rtl/data_sram_bridge_pkg.sv
// Shared types and constants for the data-side SRAM bridge: FSM encoding,
// bus size codes, size-decode result and the kseg0/kseg1 window helpers.
package data_sram_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } bridge_state_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic [31:0] KSEG_BASE  = 32'h8000_0000;
  localparam logic [31:0] KSEG_LIMIT = 32'hBFFF_FFFF;

  typedef struct packed {
    logic       wr;
    logic [1:0] size;
    logic [1:0] lane;
  } size_dec_t;

  function automatic logic in_kseg01(input logic [31:0] addr);
    return (addr >= KSEG_BASE) && (addr <= KSEG_LIMIT);
  endfunction

  // Unmapped segments drop the top three bits to reach physical space.
  function automatic logic [31:0] kseg_strip(input logic [31:0] addr);
    return {3'b000, addr[28:0]};
  endfunction

endpackage

// File: rtl/dmem_size_decode.sv
// Byte-enable decoder: maps MemWenM to bus direction, transfer size and the
// low two address bits. Reads always go out as aligned words.
module dmem_size_decode
  import data_sram_bridge_pkg::*;
(
  input  logic [3:0] wen,
  output size_dec_t  dec
);

  // Pure lookup; unrecognised enable patterns fall back to a full word.
  always_comb begin
    dec.wr   = 1'b1;
    dec.size = SIZE_WORD;
    dec.lane = 2'b00;
    case (wen)
      4'b0000: begin dec.wr = 1'b0; dec.size = SIZE_WORD; dec.lane = 2'b00; end
      4'b1111: begin dec.size = SIZE_WORD; dec.lane = 2'b00; end
      4'b0011: begin dec.size = SIZE_HALF; dec.lane = 2'b00; end
      4'b1100: begin dec.size = SIZE_HALF; dec.lane = 2'b10; end
      4'b0001: begin dec.size = SIZE_BYTE; dec.lane = 2'b00; end
      4'b0010: begin dec.size = SIZE_BYTE; dec.lane = 2'b01; end
      4'b0100: begin dec.size = SIZE_BYTE; dec.lane = 2'b10; end
      4'b1000: begin dec.size = SIZE_BYTE; dec.lane = 2'b11; end
      default: begin dec.size = SIZE_WORD; dec.lane = 2'b00; end
    endcase
  end

endmodule

// File: rtl/data_sram_bridge.sv
// MEM-stage to data SRAM-like bus bridge: one outstanding req/addr_ok/data_ok
// transaction, pipeline stall while busy. Optional macro DMEM_KSEG_MAP_EN.
module data_sram_bridge
  import data_sram_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        MemEnableM,
  input  logic [3:0]  MemWenM,
  input  logic [31:0] MemAddrM,
  input  logic [31:0] TWriteDataM,
  input  logic        ExceptDealM,
  input  logic        PipeStall,
  output logic [31:0] ReadDataM,
  output logic        MemStallM,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  bridge_state_t state_r;
  logic          discard_r;
  logic          issue_s;
  logic          cancel_s;
  size_dec_t     dec_s;
  logic [31:0]   phys_addr_s;

  dmem_size_decode u_size_decode (
    .wen (MemWenM),
    .dec (dec_s)
  );

  assign issue_s  = MemEnableM & ~ExceptDealM;
  // A cancel seen in the completing cycle discards the result just the same.
  assign cancel_s = discard_r | ExceptDealM;

`ifdef DMEM_KSEG_MAP_EN
  assign phys_addr_s = in_kseg01(MemAddrM) ? kseg_strip(MemAddrM) : MemAddrM;
`else
  assign phys_addr_s = MemAddrM;
`endif

  // Bus-side outputs follow the held MEM inputs; forced to zero under reset.
  always_comb begin
    data_req   = 1'b0;
    MemStallM  = 1'b0;
    data_wr    = 1'b0;
    data_size  = SIZE_BYTE;
    data_addr  = 32'd0;
    data_wdata = 32'd0;
    if (rst) begin
      data_req   = 1'b0;
      MemStallM  = 1'b0;
    end else begin
      data_req   = ((state_r == ST_IDLE) && issue_s) || (state_r == ST_REQ);
      MemStallM  = ((state_r == ST_IDLE) && issue_s) || (state_r == ST_REQ) ||
                   (state_r == ST_WAIT);
      data_wr    = dec_s.wr;
      data_size  = dec_s.size;
      data_addr  = (phys_addr_s & 32'hFFFF_FFFC) | {30'd0, dec_s.lane};
      data_wdata = TWriteDataM;
    end
  end

  // Transaction FSM; ReadDataM only moves on entry to DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      discard_r <= 1'b0;
      ReadDataM <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          discard_r <= 1'b0;
          if (issue_s) begin
            if (data_addr_ok && data_data_ok) begin
              state_r   <= ST_DONE;
              ReadDataM <= data_rdata;
            end else if (data_addr_ok) begin
              state_r <= ST_WAIT;
            end else begin
              state_r <= ST_REQ;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_REQ: begin
          if (data_addr_ok && data_data_ok) begin
            discard_r <= 1'b0;
            if (cancel_s) begin
              state_r <= ST_IDLE;
            end else begin
              state_r   <= ST_DONE;
              ReadDataM <= data_rdata;
            end
          end else if (data_addr_ok) begin
            state_r   <= ST_WAIT;
            discard_r <= cancel_s;
          end else begin
            state_r   <= ST_REQ;
            discard_r <= cancel_s;
          end
        end
        ST_WAIT: begin
          if (data_data_ok) begin
            discard_r <= 1'b0;
            if (cancel_s) begin
              state_r <= ST_IDLE;
            end else begin
              state_r   <= ST_DONE;
              ReadDataM <= data_rdata;
            end
          end else begin
            state_r   <= ST_WAIT;
            discard_r <= cancel_s;
          end
        end
        ST_DONE: begin
          discard_r <= 1'b0;
          if (!PipeStall) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_DONE;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          discard_r <= 1'b0;
        end
      endcase
    end
  end

endmodule
